serial_add_ctrl: RTL and testbench

- Sequencing controller for the team's bit-serial adder, with the serial add/sub datapath built in: a one-bit full adder plus a carry flop.
- Accepts two WIDTH-bit operands on a start pulse and shifts them LSB-first through the adder, one bit per enabled clock.
- Assembles the sum in a shift register, then reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a register-file/ALU front end and the serial adder, turning it into a word-level operation.

---
 rtl/serial_add_ctrl.sv | 97 +++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Word-level sequencer around a bit-serial full adder: latches two operands,
// adds/subtracts them LSB-first one bit per enabled clock, and reports sum, carry-out and overflow.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             c_msb_in;
    logic [CNT_W-1:0] counter;
    logic             bit_sum;
    logic             carry_nxt;

    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    assign busy = (state != IDLE);
    assign done = (state == DONE_ST);

    // Subtraction is folded in at load time: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            counter  <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in ^ {WIDTH{sub}};
                        carry   <= sub;
                        counter <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        carry   <= carry_nxt;
                        sum     <= {bit_sum, sum[WIDTH-1:1]};
                        a_sh    <= a_sh >> 1;
                        b_sh    <= b_sh >> 1;
                        counter <= counter + 1'b1;
                        // Carry into the MSB is kept so overflow can be formed on the final edge.
                        if (counter == CNT_PENULT) begin
                            c_msb_in <= carry_nxt;
                        end
                        if (counter == CNT_LAST) begin
                            cout  <= carry_nxt;
                            ovf   <= c_msb_in ^ carry_nxt;
                            state <= DONE_ST;
                        end
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: table-driven and random operations scored
// through an expected-result queue, plus stall, mid-operation disturbance and async reset sequences.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        exp_t             exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .en   (en),
        .a_in (a_in),
        .b_in (b_in),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic written at word level, independent of the serial datapath.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        exp_t             r;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Scoreboard side: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", int'(sum), int'(e.sum));
                check("cout", int'(cout), int'(e.cout));
                check("ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input exp_t e, input int stalls, input bit disturb);
        int edges;
        int stalls_left;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        en    = (stalls == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(e);
        check("busy_after_accept", int'(busy), 1);
        edges       = 0;
        stalls_left = stalls;
        forever begin
            if (stalls_left > 0 && (edges == 1 || edges == 2 || edges == 4)) begin
                en = 1'b0;
                stalls_left--;
            end else begin
                en = 1'b1;
            end
            if (disturb && edges == 3) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = a ^ b;
                sub   = ~s;
            end
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            if (done) break;
            if (edges > 60) begin
                check("timeout_waiting_done", edges, WIDTH + stalls);
                return;
            end
            if (busy !== 1'b1) check("busy_during_shift", int'(busy), 1);
        end
        check("latency_edges", edges, WIDTH + stalls);
        check("busy_in_done", int'(busy), 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        check("busy_back_idle", int'(busy), 0);
        check("sum_hold", int'(sum), int'(e.sum));
    endtask

    task automatic reset_abort_seq();
        @(negedge clk);
        a_in  = 8'h3C;
        b_in  = 8'h0F;
        sub   = 1'b0;
        start = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("partial_sum_nonzero", int'(sum != '0), 1);
        rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t table_v[6];

    initial begin
        table_v[0] = '{a: 8'h3C, b: 8'h0F, sub: 1'b0, exp: '{sum: 8'h4B, cout: 1'b0, ovf: 1'b0}};
        table_v[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}};
        table_v[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, exp: '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}};
        table_v[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, exp: '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0}};
        table_v[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, exp: '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1}};
        table_v[5] = '{a: 8'h12, b: 8'h34, sub: 1'b0, exp: '{sum: 8'h46, cout: 1'b0, ovf: 1'b0}};

        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sum", int'(sum), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(table_v[i].a, table_v[i].b, table_v[i].sub, table_v[i].exp, 0, 1'b0);
        end

        run_op(8'h3C, 8'h0F, 1'b0, '{sum: 8'h4B, cout: 1'b0, ovf: 1'b0}, 3, 1'b0);
        run_op(8'h3C, 8'h0F, 1'b0, '{sum: 8'h4B, cout: 1'b0, ovf: 1'b0}, 0, 1'b1);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rs;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, model(ra, rb, rs), 0, 1'b0);
        end

        reset_abort_seq();
        check("aborted_not_pending", sb_q.size(), 0);
        run_op(8'h12, 8'h34, 1'b0, '{sum: 8'h46, cout: 1'b0, ovf: 1'b0}, 0, 1'b0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
